// File: rtl/harmonic_synth.sv
// harmonic_synth: additive Fourier synthesiser, 8 cosine + 8 sine harmonics summed serially per sample.
// Build option: define HSYNTH_OFFSET_BIN_EN for an offset-binary sample_out (unsigned DACs).
module harmonic_synth #(
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               sample_tick,
    input  logic [7:0][7:0]    amplitude,
    input  logic [7:0][7:0]    amplitude_sin,
    output logic [OUT_W-1:0]   sample_out,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);
    localparam int ACC_W = (OUT_W + 2 > 24) ? OUT_W + 2 : 24;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef HSYNTH_OFFSET_BIN_EN
    localparam logic [OUT_W-1:0] OUT_FLIP = {1'b1, {(OUT_W-1){1'b0}}};
`else
    localparam logic [OUT_W-1:0] OUT_FLIP = {OUT_W{1'b0}};
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    // First quadrant of round(127*sin(2*pi*j/256)), j = 0..64.
    function automatic logic [7:0] quarter_wave(input logic [6:0] j);
        logic [7:0] q;
        case (j)
            7'd0:  q = 8'd0;   7'd1:  q = 8'd3;   7'd2:  q = 8'd6;   7'd3:  q = 8'd9;
            7'd4:  q = 8'd12;  7'd5:  q = 8'd16;  7'd6:  q = 8'd19;  7'd7:  q = 8'd22;
            7'd8:  q = 8'd25;  7'd9:  q = 8'd28;  7'd10: q = 8'd31;  7'd11: q = 8'd34;
            7'd12: q = 8'd37;  7'd13: q = 8'd40;  7'd14: q = 8'd43;  7'd15: q = 8'd46;
            7'd16: q = 8'd49;  7'd17: q = 8'd51;  7'd18: q = 8'd54;  7'd19: q = 8'd57;
            7'd20: q = 8'd60;  7'd21: q = 8'd63;  7'd22: q = 8'd65;  7'd23: q = 8'd68;
            7'd24: q = 8'd71;  7'd25: q = 8'd73;  7'd26: q = 8'd76;  7'd27: q = 8'd78;
            7'd28: q = 8'd81;  7'd29: q = 8'd83;  7'd30: q = 8'd85;  7'd31: q = 8'd88;
            7'd32: q = 8'd90;  7'd33: q = 8'd92;  7'd34: q = 8'd94;  7'd35: q = 8'd96;
            7'd36: q = 8'd98;  7'd37: q = 8'd100; 7'd38: q = 8'd102; 7'd39: q = 8'd104;
            7'd40: q = 8'd106; 7'd41: q = 8'd107; 7'd42: q = 8'd109; 7'd43: q = 8'd111;
            7'd44: q = 8'd112; 7'd45: q = 8'd113; 7'd46: q = 8'd115; 7'd47: q = 8'd116;
            7'd48: q = 8'd117; 7'd49: q = 8'd118; 7'd50: q = 8'd120; 7'd51: q = 8'd121;
            7'd52: q = 8'd122; 7'd53: q = 8'd122; 7'd54: q = 8'd123; 7'd55: q = 8'd124;
            7'd56: q = 8'd125; 7'd57: q = 8'd125; 7'd58: q = 8'd126; 7'd59: q = 8'd126;
            7'd60: q = 8'd126; 7'd61: q = 8'd127; 7'd62: q = 8'd127; 7'd63: q = 8'd127;
            default: q = 8'd127;
        endcase
        return q;
    endfunction

    // Full 256-entry signed sine built from quadrant symmetry.
    function automatic logic signed [7:0] sin_lut(input logic [7:0] i);
        logic [7:0] mag;
        mag = i[6] ? quarter_wave(7'd64 - {1'b0, i[5:0]}) : quarter_wave({1'b0, i[5:0]});
        return i[7] ? -$signed(mag) : $signed(mag);
    endfunction

    state_t                    state_r, state_s;
    logic [2:0]                step_r;
    logic [PHASE_W-1:0]        phase_acc_r, h_r;
    logic [7:0][7:0]           amp_cos_r, amp_sin_r;
    logic [7:0]                lut_addr_s;
    logic signed [7:0]         cos_r, sin_r;
    logic [7:0]                ac_r, as_r;
    logic                      v1_r, v2_r, v3_r;
    logic signed [16:0]        pc_r, ps_r;
    logic signed [17:0]        term_r;
    logic signed [ACC_W-1:0]   acc_r, shifted_s;
    logic [OUT_W-1:0]          sat_s, out_r;
    logic                      valid_r, busy_r, overrun_r, accept_s;

    // busy_r also covers the sample_valid cycle, so a tick there is rejected.
    assign accept_s   = sample_tick && (state_r == IDLE) && !busy_r;
    assign lut_addr_s = h_r[PHASE_W-1 -: 8];
    assign shifted_s  = acc_r >>> SHIFT;

    // Sequencer next-state: 8 RUN steps, 3 DRAIN cycles to flush the MAC pipe, 1 DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? RUN : IDLE;
            RUN:     state_s = (step_r == 3'd7) ? DRAIN : RUN;
            DRAIN:   state_s = (step_r == 3'd2) ? DONE : DRAIN;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register and per-state step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            step_r  <= 3'd0;
        end else begin
            state_r <= state_s;
            step_r  <= (state_s != state_r) ? 3'd0 : step_r + 3'd1;
        end
    end

    // Phase accumulator, harmonic phase by repeated addition, amplitude snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_acc_r <= {PHASE_W{1'b0}};
            h_r         <= {PHASE_W{1'b0}};
            amp_cos_r   <= {64{1'b0}};
            amp_sin_r   <= {64{1'b0}};
        end else if (accept_s) begin
            phase_acc_r <= phase_acc_r + phase_inc;
            h_r         <= phase_acc_r + phase_inc;
            amp_cos_r   <= amplitude;
            amp_sin_r   <= amplitude_sin;
        end else if (state_r == RUN) begin
            h_r <= h_r + phase_acc_r;
        end
    end

    // Three-stage term pipeline: LUT, products, term sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r   <= 1'b0;
            v2_r   <= 1'b0;
            v3_r   <= 1'b0;
            cos_r  <= 8'sd0;
            sin_r  <= 8'sd0;
            ac_r   <= 8'd0;
            as_r   <= 8'd0;
            pc_r   <= 17'sd0;
            ps_r   <= 17'sd0;
            term_r <= 18'sd0;
        end else begin
            v1_r   <= (state_r == RUN);
            cos_r  <= sin_lut(lut_addr_s + 8'd64);
            sin_r  <= sin_lut(lut_addr_s);
            ac_r   <= amp_cos_r[step_r];
            as_r   <= amp_sin_r[step_r];
            v2_r   <= v1_r;
            pc_r   <= {{9{1'b0}}, ac_r} * {{9{cos_r[7]}}, cos_r};
            ps_r   <= {{9{1'b0}}, as_r} * {{9{sin_r[7]}}, sin_r};
            v3_r   <= v2_r;
            term_r <= {pc_r[16], pc_r} + {ps_r[16], ps_r};
        end
    end

    // Accumulator is wide enough for 16 full-scale terms, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (accept_s) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (v3_r) begin
            acc_r <= acc_r + {{(ACC_W-18){term_r[17]}}, term_r};
        end
    end

    // Saturate the shifted accumulator to the output range.
    always_comb begin
        if (shifted_s > SAT_MAX) begin
            sat_s = SAT_MAX[OUT_W-1:0];
        end else if (shifted_s < SAT_MIN) begin
            sat_s = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_s = shifted_s[OUT_W-1:0];
        end
    end

    // Registered outputs and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r     <= OUT_FLIP;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            valid_r   <= (state_r == DONE);
            out_r     <= (state_r == DONE) ? (sat_s ^ OUT_FLIP) : out_r;
            busy_r    <= accept_s ? 1'b1 : (valid_r ? 1'b0 : busy_r);
            overrun_r <= overrun_r | (sample_tick & ~accept_s);
        end
    end

    assign sample_out   = out_r;
    assign sample_valid = valid_r;
    assign busy         = busy_r;
    assign overrun      = overrun_r;
endmodule
